bcd_entry_sequencer: RTL and testbench
======================================

# bcd_entry_sequencer

Sequences keypad digit entry into the shared two-digit BCD-to-binary converter and hands the validated binary value to a downstream consumer over a valid/ready handshake. It accepts up to two decimal digits (tens, ones) plus CLEAR/ENTER keys. On ENTER it runs one conversion through an internal `BCD_Binary` instance, range-checks the result against `MAX_VALUE`, and then either holds the value for the consumer or signals an error. It sits between the keypad decoder and the game timer/counter load logic. It also drives the two entered digits to the seven-segment display path.

## Interface
- `MAX_VALUE`, default 59. Largest accepted binary value; legal range 0..59.
- `TIMEOUT_CYCLES`, default 1000. Idle cycles allowed between keys before a partial entry is discarded; minimum 2.
- `Clk`  in  1  System clock; all state changes on the rising edge.
- `Rst`  in  1  Asynchronous, active-low reset.
- `key_valid`  in  1  One-cycle strobe qualifying `key_code`.
- `key_code`  in  4  Key code: 0..9 are digits, 4'hA is CLEAR, 4'hB is ENTER; 4'hC..4'hF are ignored.
- `out_ready`  in  1  Consumer accepts `bin_out` when high together with `bin_valid`.
- `bin_out`  out  6  Registered converted value, held stable while `bin_valid` is high.
- `bin_valid`  out  1  Converted value is available.
- `entry_err`  out  1  One-cycle pulse: range error or entry timeout.
- `tens_digit`  out  4  Currently entered tens digit, for display.
- `ones_digit`  out  4  Currently entered ones digit, for display.
- `busy`  out  1  High in CONV and HOLD; keys are ignored while high.

## Operation
- Reset (async, `Rst`=0): state IDLE. `bin_out`=0, `bin_valid`=0, `entry_err`=0, `tens_digit`=0, `ones_digit`=0, `busy`=0, timeout counter=0.
- States: IDLE (no digits entered), ONE (one digit), TWO (two digits), CONV, HOLD, ERR.
- Digit key, shift-in behaviour:
  - In IDLE: `ones_digit`<=d, `tens_digit`<=0, go to ONE.
  - In ONE: `tens_digit`<=`ones_digit`, `ones_digit`<=d, go to TWO.
  - In TWO: ignored; the digits are unchanged.
- CLEAR in IDLE, ONE or TWO: both digits go to 0, next state IDLE, no error.
- ENTER:
  - In IDLE: ignored.
  - In ONE or TWO: go to CONV.
- CONV lasts exactly one cycle. The internal `BCD_Binary` is driven combinationally from the digit registers.
  - If `tens_digit`>5, or the converter result > `MAX_VALUE`: go to ERR. The tens check is required because the converter maps tens >5 to 0.
  - Otherwise: `bin_out`<=result, `bin_valid`<=1, go to HOLD.
- HOLD: `bin_valid`=1 and `bin_out` stable until a cycle with `out_ready`=1. On that edge `bin_valid`<=0, both digits clear, and the state goes to IDLE. `bin_out` keeps its last value.
- ERR: `entry_err`=1 for exactly one cycle. Both digits clear, `bin_out` is unchanged, next state IDLE.
- Timeout counter:
  - Counts only in ONE and TWO.
  - Zeroed on any accepted key and in every other state.
  - When it reaches `TIMEOUT_CYCLES`-1 with no key that cycle, go to ERR.
- Keys in CONV, HOLD or ERR are dropped, not queued.
- `busy`, `bin_valid` and `entry_err` are registered state decodes; none is combinational from inputs.

## Timing
- ENTER sampled at edge t → CONV during cycle t+1 → `bin_valid`=1 (or `entry_err`=1) from edge t+2.
- Key-to-display latency: `tens_digit`/`ones_digit` update on the edge that samples `key_valid`.
- Handshake: transfer happens on the first edge with `bin_valid`&&`out_ready`. `out_ready` held high in advance gives a one-cycle HOLD. The earliest next entry key is accepted one cycle after the transfer edge.
- Key and timeout in the same cycle: the key wins and the counter is zeroed.
- CLEAR and timeout in the same cycle: CLEAR wins; no `entry_err`.
- `Rst` asserted mid-CONV or mid-HOLD: immediate return to reset values; the pending value is lost and no `entry_err` is produced.
- Maximum `bin_out`=59 fits in 6 bits. No wrap is possible because out-of-range values never reach `bin_out`.

## Test plan
- Reset, then keys 4, 2, ENTER with `out_ready`=1 → `bin_out`=42 with `bin_valid` high for 1 cycle, two cycles after ENTER.
- Key 7, ENTER → `tens_digit`=0, `ones_digit`=7, then `bin_out`=7. Hold `out_ready`=0 for 5 cycles → `bin_valid` stays high and `bin_out` stays 7 throughout.
- Keys 6, 3, ENTER → `entry_err` 1-cycle pulse, `bin_valid` never asserts, digits return to 0. Keys 5, 9, ENTER → `bin_out`=59.
- Key 1, then no key for `TIMEOUT_CYCLES` cycles → `entry_err` pulse on cycle `TIMEOUT_CYCLES`+1, state IDLE. Repeat with a key 2 on the boundary cycle → no error; digits become 1, 2.
- Keys 3, 8, 9 (third ignored), CLEAR, ENTER → no conversion and digits are 0. Keys during HOLD are dropped, and `bin_out` is unchanged after the transfer.
- `Rst` pulsed low during CONV → all outputs return to 0 asynchronously, and the next entry 2, 5, ENTER yields 25.

Source files
------------

// File: rtl/bcd_entry_sequencer.sv
// Keypad digit entry sequencer: collects up to two BCD digits, converts on ENTER,
// range-checks the result and offers it to a consumer over a valid/ready handshake.

module BCD_Binary (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [5:0] bin
);
    logic [5:0] w_tens_val;

    // Tens digits above 5 contribute nothing; the caller must reject them separately.
    always_comb begin
        case (tens)
            4'd1:    w_tens_val = 6'd10;
            4'd2:    w_tens_val = 6'd20;
            4'd3:    w_tens_val = 6'd30;
            4'd4:    w_tens_val = 6'd40;
            4'd5:    w_tens_val = 6'd50;
            default: w_tens_val = 6'd0;
        endcase
        bin = w_tens_val + {2'b00, ones};
    end
endmodule

module bcd_entry_sequencer #(
    parameter int MAX_VALUE      = 59,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       out_ready,
    output logic [5:0] bin_out,
    output logic       bin_valid,
    output logic       entry_err,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic       busy
);
    localparam int         CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] MAX_V = 6'(MAX_VALUE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ONE,
        S_TWO,
        S_CONV,
        S_HOLD,
        S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_tens, r_ones, w_tens_nxt, w_ones_nxt;
    logic [5:0]       r_bin, w_bin_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [5:0]       w_conv;
    logic             w_digit, w_clear, w_enter, w_timeout;

    BCD_Binary u_bcd (
        .tens (r_tens),
        .ones (r_ones),
        .bin  (w_conv)
    );

    assign w_digit   = key_valid && (key_code <= 4'd9);
    assign w_clear   = key_valid && (key_code == 4'hA);
    assign w_enter   = key_valid && (key_code == 4'hB);
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_bin   <= 6'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_bin   <= w_bin_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_digit) begin
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = key_code;
                    w_state_nxt = S_ONE;
                end else if (w_clear) begin
                    w_tens_nxt = 4'd0;
                    w_ones_nxt = 4'd0;
                end
            end
            S_ONE, S_TWO: begin
                // An accepted key always beats a timeout landing on the same edge.
                if (w_digit && r_state == S_ONE) begin
                    w_tens_nxt  = r_ones;
                    w_ones_nxt  = key_code;
                    w_state_nxt = S_TWO;
                end else if (w_clear) begin
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (w_enter) begin
                    w_state_nxt = S_CONV;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CONV: begin
                if (r_tens > 4'd5 || w_conv > MAX_V) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_bin_nxt   = w_conv;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_tens_nxt  = 4'd0;
                w_ones_nxt  = 4'd0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bin_out    = r_bin;
    assign tens_digit = r_tens;
    assign ones_digit = r_ones;
    assign bin_valid  = (r_state == S_HOLD);
    assign entry_err  = (r_state == S_ERR);
    assign busy       = (r_state == S_CONV) || (r_state == S_HOLD);
endmodule

// File: tb/tb_bcd_entry_sequencer.sv
// Directed bench for bcd_entry_sequencer: inputs driven and outputs sampled on the falling edge.

module tb_bcd_entry_sequencer;
    localparam int T = 1000;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       out_ready;
    logic [5:0] bin_out;
    logic       bin_valid;
    logic       entry_err;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_entry_sequencer #(.MAX_VALUE(59), .TIMEOUT_CYCLES(T)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .out_ready  (out_ready),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .entry_err  (entry_err),
        .tens_digit (tens_digit),
        .ones_digit (ones_digit),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge Clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_digits(input string tag, input logic [3:0] t, input logic [3:0] o);
        check({tag, "_tens"}, 32'(tens_digit), 32'(t));
        check({tag, "_ones"}, 32'(ones_digit), 32'(o));
    endtask

    initial begin
        Rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;
        #12;
        check("rst_bin_out", 32'(bin_out), 0);
        check("rst_bin_valid", 32'(bin_valid), 0);
        check("rst_entry_err", 32'(entry_err), 0);
        check("rst_busy", 32'(busy), 0);
        check_digits("rst", 4'd0, 4'd0);
        @(negedge Clk); Rst = 1'b1;

        // 4, 2, ENTER with consumer ready
        out_ready = 1'b1;
        press(4'd4); check_digits("k4", 4'd0, 4'd4);
        press(4'd2); check_digits("k42", 4'd4, 4'd2);
        press(4'hB);
        check("t1_conv_busy", 32'(busy), 1);
        check("t1_conv_valid", 32'(bin_valid), 0);
        idle(1);
        check("t1_valid", 32'(bin_valid), 1);
        check("t1_bin", 32'(bin_out), 42);
        idle(1);
        check("t1_valid_drop", 32'(bin_valid), 0);
        check("t1_bin_keep", 32'(bin_out), 42);
        check("t1_busy_drop", 32'(busy), 0);
        check_digits("t1_clr", 4'd0, 4'd0);

        // 7, ENTER with consumer stalled; key in HOLD is dropped
        out_ready = 1'b0;
        press(4'd7); check_digits("k7", 4'd0, 4'd7);
        press(4'hB);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", 32'(bin_valid), 1);
            check("t2_hold_bin", 32'(bin_out), 7);
            idle(1);
        end
        press(4'd9);
        check("t2_drop_valid", 32'(bin_valid), 1);
        check_digits("t2_drop", 4'd0, 4'd7);
        out_ready = 1'b1;
        idle(1);
        check("t2_xfer_valid", 32'(bin_valid), 0);
        check("t2_xfer_bin", 32'(bin_out), 7);
        check_digits("t2_xfer", 4'd0, 4'd0);

        // 6, 3 is out of range
        press(4'd6); press(4'd3); press(4'hB);
        idle(1);
        check("t3_err", 32'(entry_err), 1);
        check("t3_err_valid", 32'(bin_valid), 0);
        idle(1);
        check("t3_err_pulse", 32'(entry_err), 0);
        check("t3_bin_keep", 32'(bin_out), 7);
        check_digits("t3_clr", 4'd0, 4'd0);

        press(4'd5); press(4'd9); press(4'hB);
        idle(1);
        check("t3_59_valid", 32'(bin_valid), 1);
        check("t3_59_bin", 32'(bin_out), 59);
        idle(1);

        // timeout after key 1
        press(4'd1);
        idle(T - 1);
        check("t4_pre_err", 32'(entry_err), 0);
        check("t4_pre_ones", 32'(ones_digit), 1);
        idle(1);
        check("t4_err", 32'(entry_err), 1);
        idle(1);
        check("t4_err_pulse", 32'(entry_err), 0);
        check_digits("t4_clr", 4'd0, 4'd0);

        // key on the boundary cycle wins
        press(4'd1);
        idle(T - 1);
        press(4'd2);
        check("t4b_err", 32'(entry_err), 0);
        check_digits("t4b", 4'd1, 4'd2);
        press(4'hA);
        check_digits("t4b_clr", 4'd0, 4'd0);

        // CLEAR on the boundary cycle wins
        press(4'd3);
        idle(T - 1);
        press(4'hA);
        check("t4c_err", 32'(entry_err), 0);
        idle(1);
        check("t4c_err2", 32'(entry_err), 0);
        check_digits("t4c", 4'd0, 4'd0);

        // third digit ignored, CLEAR, ENTER in IDLE ignored
        press(4'd3); press(4'd8); press(4'd9);
        check_digits("t5_389", 4'd3, 4'd8);
        press(4'hA);
        check_digits("t5_clr", 4'd0, 4'd0);
        press(4'hB);
        check("t5_busy", 32'(busy), 0);
        idle(1);
        check("t5_valid", 32'(bin_valid), 0);
        check("t5_err", 32'(entry_err), 0);

        // reset during CONV
        press(4'd1); press(4'd7); press(4'hB);
        check("t6_conv", 32'(busy), 1);
        Rst = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_bin", 32'(bin_out), 0);
        check_digits("t6_rst", 4'd0, 4'd0);
        @(negedge Clk); Rst = 1'b1;
        idle(1);
        check("t6_err", 32'(entry_err), 0);
        check("t6_valid", 32'(bin_valid), 0);
        press(4'd2); press(4'd5); press(4'hB);
        idle(1);
        check("t6_25_valid", 32'(bin_valid), 1);
        check("t6_25_bin", 32'(bin_out), 25);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
